blake2_feeder: RTL and testbench

Host-side driver for the blake2 core's byte-serial block interface. It takes a byte stream holding the optional key followed by the message. It segments the stream into 64-byte blocks, zero-pads the key block and the final block, and drives the core's `data_*`, `block_first`, `block_last`, `ll`, `kk` and `nn` inputs. It then captures the core's `h_v`/`h_o` result burst, in fast or slow mode, and re-emits it as a clean one-byte-per-beat digest stream to the host.

---
 rtl/blake2_feeder.sv | 185 ++++++++++++++++++
 tb/tb_blake2_feeder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2_feeder.sv
// blake2_feeder: segments a key+message byte stream into 64-byte core blocks
// and re-emits the core's digest burst as a one-byte-per-beat stream.
module blake2_feeder #(
  parameter int BB   = 64,
  parameter int NN_W = 6,
  parameter int LL_W = 64
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   start_i,
  input  logic [NN_W-1:0]        kk_i,
  input  logic [NN_W-1:0]        nn_i,
  input  logic                   empty_i,
  input  logic                   slow_i,
  input  logic                   msg_valid_i,
  input  logic [7:0]             msg_data_i,
  input  logic                   msg_last_i,
  output logic                   msg_ready_o,
  input  logic                   core_ready_i,
  output logic                   core_data_v_o,
  output logic [$clog2(BB)-1:0]  core_data_idx_o,
  output logic [7:0]             core_data_o,
  output logic                   core_first_o,
  output logic                   core_last_o,
  output logic                   core_slow_o,
  output logic [NN_W-1:0]        core_kk_o,
  output logic [NN_W-1:0]        core_nn_o,
  output logic [LL_W-1:0]        core_ll_o,
  input  logic                   core_h_v_i,
  input  logic [7:0]             core_h_i,
  output logic                   res_valid_o,
  output logic [7:0]             res_data_o,
  output logic                   res_last_o,
  output logic                   busy_o
);

  localparam int IW = $clog2(BB);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_KPAD, S_MSG, S_PAD, S_WAIT, S_RES
  } state_t;

  state_t          state_q, state_d;
  logic [NN_W-1:0] kk_q, nn_q, rcnt_q;
  logic            empty_q, slow_q;
  logic [IW-1:0]   idx_q;
  logic [LL_W-1:0] cnt_q;
  logic            first_q;
  logic [1:0]      lead_q;
  logic            ph_q;
  logic            res_valid_q, res_last_q;
  logic [7:0]      res_data_q;
  logic            beat, cap, last_idx;

  assign last_idx        = (idx_q == IW'(BB - 1));
  assign core_data_idx_o = idx_q;
  assign core_first_o    = first_q;
  assign core_slow_o     = slow_q;
  assign core_kk_o       = kk_q;
  assign core_nn_o       = nn_q;
  assign core_ll_o       = cnt_q + ((kk_q != '0) ? LL_W'(BB) : '0);
  assign res_valid_o     = res_valid_q;
  assign res_data_o      = res_data_q;
  assign res_last_o      = res_last_q;
  assign busy_o          = (state_q != S_IDLE);

  // Next state, core/host handshake and capture strobe.
  always_comb begin
    state_d       = state_q;
    core_data_v_o = 1'b0;
    msg_ready_o   = 1'b0;
    core_data_o   = 8'h00;
    core_last_o   = 1'b0;
    beat          = 1'b0;
    cap           = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (kk_i != '0)   state_d = S_KEY;
          else if (empty_i) state_d = S_PAD;
          else              state_d = S_MSG;
        end
      end
      S_KEY: begin
        msg_ready_o   = core_ready_i;
        core_data_v_o = msg_valid_i & core_ready_i;
        core_data_o   = msg_data_i;
        beat          = core_data_v_o;
        if (beat && idx_q == IW'(kk_q - NN_W'(1))) begin
          if (!last_idx)    state_d = S_KPAD;
          else if (empty_q) state_d = S_PAD;
          else              state_d = S_MSG;
        end
      end
      S_KPAD: begin
        core_data_v_o = core_ready_i;
        core_last_o   = empty_q;
        beat          = core_ready_i;
        if (beat && last_idx)
          state_d = empty_q ? S_PAD : S_MSG;
      end
      S_MSG: begin
        msg_ready_o   = core_ready_i;
        core_data_v_o = msg_valid_i & core_ready_i;
        core_data_o   = msg_data_i;
        core_last_o   = msg_last_i;
        beat          = core_data_v_o;
        if (beat && msg_last_i)
          state_d = last_idx ? S_WAIT : S_PAD;
      end
      S_PAD: begin
        core_data_v_o = core_ready_i;
        core_last_o   = 1'b1;
        beat          = core_ready_i;
        if (beat && last_idx) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_h_v_i) state_d = S_RES;
      end
      S_RES: begin
        cap = core_h_v_i && lead_q == 2'd0 && (!slow_q || !ph_q);
        if (cap && rcnt_q == nn_q - NN_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Block position, length count and digest capture registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      kk_q        <= '0;
      nn_q        <= '0;
      empty_q     <= 1'b0;
      slow_q      <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      lead_q      <= 2'd0;
      ph_q        <= 1'b0;
      rcnt_q      <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start_i) begin
        kk_q    <= kk_i;
        nn_q    <= nn_i;
        empty_q <= empty_i;
        slow_q  <= slow_i;
        idx_q   <= '0;
        cnt_q   <= '0;
        first_q <= 1'b1;
      end
      if (beat) begin
        idx_q <= idx_q + IW'(1);
        if (last_idx) first_q <= 1'b0;
      end
      if (beat && state_q == S_MSG)
        cnt_q <= cnt_q + LL_W'(1);
      if (state_q == S_WAIT && core_h_v_i) begin
        lead_q <= slow_q ? 2'd2 : 2'd1;
        ph_q   <= 1'b0;
        rcnt_q <= '0;
      end
      if (state_q == S_RES && core_h_v_i) begin
        if (lead_q != 2'd0) lead_q <= lead_q - 2'd1;
        else                ph_q   <= slow_q & ~ph_q;
      end
      res_valid_q <= cap;
      res_last_q  <= cap && (rcnt_q == nn_q - NN_W'(1));
      if (cap) begin
        res_data_q <= core_h_i;
        rcnt_q     <= rcnt_q + NN_W'(1);
      end
    end
  end

  // The core must keep h_v up for the whole digest burst.
  res_hv_held: assert property (
    @(posedge clk) disable iff (!nreset)
    (state_q == S_RES) |-> core_h_v_i);

endmodule

// File: tb/tb_blake2_feeder.sv
// tb_blake2_feeder: directed checks of block segmentation, padding,
// flags, length and digest re-emission for blake2_feeder.
module tb_blake2_feeder;

  logic        clk = 0;
  logic        nreset;
  logic        start_i;
  logic [5:0]  kk_i, nn_i;
  logic        empty_i, slow_i;
  logic        msg_valid_i;
  logic [7:0]  msg_data_i;
  logic        msg_last_i;
  logic        msg_ready_o;
  logic        core_ready_i;
  logic        core_data_v_o;
  logic [5:0]  core_data_idx_o;
  logic [7:0]  core_data_o;
  logic        core_first_o, core_last_o, core_slow_o;
  logic [5:0]  core_kk_o, core_nn_o;
  logic [63:0] core_ll_o;
  logic        core_h_v_i;
  logic [7:0]  core_h_i;
  logic        res_valid_o;
  logic [7:0]  res_data_o;
  logic        res_last_o;
  logic        busy_o;

  blake2_feeder dut (
    .clk(clk), .nreset(nreset), .start_i(start_i),
    .kk_i(kk_i), .nn_i(nn_i), .empty_i(empty_i), .slow_i(slow_i),
    .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i),
    .msg_last_i(msg_last_i), .msg_ready_o(msg_ready_o),
    .core_ready_i(core_ready_i), .core_data_v_o(core_data_v_o),
    .core_data_idx_o(core_data_idx_o), .core_data_o(core_data_o),
    .core_first_o(core_first_o), .core_last_o(core_last_o),
    .core_slow_o(core_slow_o), .core_kk_o(core_kk_o),
    .core_nn_o(core_nn_o), .core_ll_o(core_ll_o),
    .core_h_v_i(core_h_v_i), .core_h_i(core_h_i),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o),
    .res_last_o(res_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int blk_done = 0;
  int stall = 0;
  int b0;

  logic [15:0] bq[$];
  logic [15:0] eq[$];
  logic [7:0]  r_dat[$];
  logic        r_last[$];
  int          r_cyc[$];
  logic [7:0]  hs[0:79];
  logic [7:0]  er[0:31];

  assign core_ready_i = (stall == 0);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!nreset) stall <= 0;
    else if (core_data_v_o && core_data_idx_o == 6'd63) stall <= 3;
    else if (stall != 0) stall <= stall - 1;
  end

  always @(posedge clk) begin
    if (nreset && msg_valid_i && msg_ready_o) acc_cnt <= acc_cnt + 1;
    if (nreset && core_data_v_o) begin
      bq.push_back({core_data_idx_o, core_data_o, core_first_o, core_last_o});
      if (core_data_idx_o == 6'd63 && core_last_o) blk_done <= blk_done + 1;
    end
    if (res_valid_o) begin
      r_dat.push_back(res_data_o);
      r_last.push_back(res_last_o);
      r_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pe(input int idx, input logic [7:0] d,
                    input logic f, input logic l);
    eq.push_back({6'(idx), d, f, l});
  endtask

  task automatic start_hash(input int kk, input int nn,
                            input logic emp, input logic slw);
    bq.delete(); eq.delete();
    r_dat.delete(); r_last.delete(); r_cyc.delete();
    b0 = blk_done;
    kk_i = 6'(kk); nn_i = 6'(nn); empty_i = emp; slow_i = slw;
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    kk_i = 0; nn_i = 0; empty_i = 0; slow_i = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int a0, t;
    a0 = acc_cnt; t = 0;
    msg_valid_i = 1; msg_data_i = d; msg_last_i = l;
    do begin @(negedge clk); t++; end
    while (acc_cnt == a0 && t < 50);
    chk("send_accept", 64'(acc_cnt - a0), 1);
  endtask

  task automatic idle_host();
    msg_valid_i = 0; msg_data_i = 0; msg_last_i = 0;
  endtask

  task automatic fill_ref(input logic [255:0] r);
    for (int j = 0; j < 80; j++) hs[j] = 8'hEE;
    for (int k = 0; k < 32; k++) begin
      er[k] = r[255-8*k -: 8];
      hs[k+2] = er[k];
    end
  endtask

  task automatic fill_pat(input logic [7:0] base, input logic slw);
    for (int j = 0; j < 80; j++) hs[j] = base + 8'(j);
    for (int k = 0; k < 32; k++)
      er[k] = slw ? base + 8'(3 + 2*k) : base + 8'(2 + k);
  endtask

  task automatic run_res(input string tag, input logic [63:0] ll_exp);
    int t, j;
    t = 0;
    while (blk_done == b0 && t < 2000) begin @(negedge clk); t++; end
    chk({tag, "_blk_done"}, 64'(blk_done - b0), 1);
    chk({tag, "_ll"}, core_ll_o, ll_exp);
    j = 0;
    while (busy_o && j < 80) begin
      core_h_v_i = 1; core_h_i = hs[j]; j++;
      @(negedge clk);
    end
    core_h_v_i = 0; core_h_i = 0;
    chk({tag, "_busy_end"}, busy_o, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_beats(input string tag);
    int n;
    chk({tag, "_nbeats"}, bq.size(), eq.size());
    n = (bq.size() < eq.size()) ? bq.size() : eq.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_beat%0d", tag, i), bq[i], eq[i]);
  endtask

  task automatic check_res(input string tag, input int nn, input int gap);
    int n;
    chk({tag, "_nres"}, r_dat.size(), nn);
    n = (r_dat.size() < nn) ? r_dat.size() : nn;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_res%0d", tag, k), r_dat[k], er[k]);
      chk($sformatf("%s_rlast%0d", tag, k), r_last[k], (k == nn - 1));
      if (k > 0)
        chk($sformatf("%s_rgap%0d", tag, k),
            64'(r_cyc[k] - r_cyc[k-1]), 64'(gap));
    end
  endtask

  logic [7:0] m [0:64];
  logic [255:0] ref_empty, ref_abc;

  initial begin
    ref_empty = 256'h69217a3079908094e11121d042354a7c1f55b6482ca1a51e1b250dfd1ed0eef9;
    ref_abc   = 256'h508c5e8c327c14e2e1a72ba34eeb452f37458b209ed63a294d999b4c86675982;
    nreset = 0; start_i = 0; kk_i = 0; nn_i = 0; empty_i = 0; slow_i = 0;
    idle_host();
    core_h_v_i = 0; core_h_i = 0;
    repeat (3) @(negedge clk);

    chk("rst_busy", busy_o, 0);
    chk("rst_data_v", core_data_v_o, 0);
    chk("rst_msg_ready", msg_ready_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_ll", core_ll_o, 0);
    chk("rst_idx", core_data_idx_o, 0);
    chk("rst_flags", {core_first_o, core_last_o, core_slow_o}, 0);
    chk("rst_kknn", {core_kk_o, core_nn_o}, 0);
    nreset = 1;
    @(negedge clk);

    // empty, unkeyed, nn=32, fast
    fill_ref(ref_empty);
    start_hash(0, 32, 1, 0);
    chk("e_busy", busy_o, 1);
    for (int i = 0; i < 64; i++) pe(i, 0, 1, 1);
    run_res("e", 0);
    check_beats("e");
    check_res("e", 32, 1);

    // "abc", nn=32, fast
    fill_ref(ref_abc);
    start_hash(0, 32, 0, 0);
    send(8'h61, 0); send(8'h62, 0); send(8'h63, 1); idle_host();
    pe(0, 8'h61, 1, 0); pe(1, 8'h62, 1, 0); pe(2, 8'h63, 1, 1);
    for (int i = 3; i < 64; i++) pe(i, 0, 1, 1);
    run_res("abc", 3);
    check_beats("abc");
    check_res("abc", 32, 1);

    // 64-byte message ending at idx 63; start mid-message is ignored
    fill_pat(8'h40, 0);
    start_hash(0, 8, 0, 0);
    for (int i = 0; i < 64; i++) m[i] = 8'(i*3 + 1);
    for (int i = 0; i < 10; i++) send(m[i], 0);
    idle_host();
    start_i = 1; nn_i = 6'd5; kk_i = 6'd3;
    @(negedge clk);
    start_i = 0; nn_i = 0; kk_i = 0;
    chk("ign_start_nn", core_nn_o, 8);
    chk("ign_start_kk", core_kk_o, 0);
    chk("ign_start_busy", busy_o, 1);
    for (int i = 10; i < 64; i++) send(m[i], (i == 63));
    idle_host();
    for (int i = 0; i < 64; i++) pe(i, m[i], 1, (i == 63));
    run_res("m64", 64);
    check_beats("m64");
    check_res("m64", 8, 1);

    // keyed kk=32, 65-byte message; last on a key byte is ignored
    fill_pat(8'h90, 0);
    start_hash(32, 32, 0, 0);
    chk("key_kk", core_kk_o, 32);
    for (int i = 0; i < 32; i++) send(8'h80 + 8'(i), (i == 5));
    for (int i = 0; i < 65; i++) m[i] = 8'(i*7 + 3);
    for (int i = 0; i < 65; i++) send(m[i], (i == 64));
    idle_host();
    for (int i = 0; i < 32; i++) pe(i, 8'h80 + 8'(i), 1, 0);
    for (int i = 32; i < 64; i++) pe(i, 0, 1, 0);
    for (int i = 0; i < 64; i++) pe(i, m[i], 0, 0);
    pe(0, m[64], 0, 1);
    for (int i = 1; i < 64; i++) pe(i, 0, 0, 1);
    run_res("key", 129);
    check_beats("key");
    check_res("key", 32, 1);

    // slow mode, nn=16, random host gaps
    fill_pat(8'hA0, 1);
    start_hash(0, 16, 0, 1);
    chk("slow_flag", core_slow_o, 1);
    for (int i = 0; i < 10; i++) begin
      idle_host();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(8'h10 + 8'(i), (i == 9));
    end
    idle_host();
    for (int i = 0; i < 10; i++) pe(i, 8'h10 + 8'(i), 1, (i == 9));
    for (int i = 10; i < 64; i++) pe(i, 0, 1, 1);
    run_res("slow", 10);
    check_beats("slow");
    check_res("slow", 16, 2);

    // reset in the middle of a message, then a clean hash
    start_hash(0, 32, 0, 0);
    for (int i = 0; i < 5; i++) send(8'h20 + 8'(i), 0);
    msg_valid_i = 1; msg_data_i = 8'h55;
    nreset = 0;
    @(negedge clk);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_data_v", core_data_v_o, 0);
    chk("mid_rst_ready", msg_ready_o, 0);
    chk("mid_rst_ll", core_ll_o, 0);
    nreset = 1;
    idle_host();
    @(negedge clk);
    fill_pat(8'h30, 0);
    start_hash(0, 4, 0, 0);
    send(8'h78, 0); send(8'h79, 1); idle_host();
    pe(0, 8'h78, 1, 0); pe(1, 8'h79, 1, 1);
    for (int i = 2; i < 64; i++) pe(i, 0, 1, 1);
    run_res("post", 2);
    check_beats("post");
    check_res("post", 4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
